neander_x_sequencer: RTL

NEANDER_X_SEQUENCER -- requirements
Module: neander_x_sequencer

---
 rtl/neander_x_sequencer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/neander_x_sequencer.sv
// Control sequencer for the Neander-X CPU: fetch, operand fetch and execute micro-steps.
// Define NEANDER_X_INDEX_EN to enable the X-register extension (LDX/STX/LDXI/TAX/TXA/INX, indexed LDA/STA).
module neander_x_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [3:0] opcode,
   input  logic [3:0] sub_opcode,
   input  logic       flagN,
   input  logic       flagZ,
   input  logic       flagC,
   output logic       mem_read,
   output logic       mem_write,
   output logic       rdm_load,
   output logic       rem_load,
   output logic       ri_load,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       ac_load,
   output logic       nz_load,
   output logic       c_load,
   output logic       sp_inc,
   output logic       sp_dec,
   output logic       x_load,
   output logic       x_inc,
   output logic       x_to_ac,
   output logic       indexed_mode,
   output logic [1:0] addr_sel,
   output logic [1:0] mem_data_sel,
   output logic [3:0] alu_op,
   output logic       alu_b_sel,
   output logic       io_write_ctrl,
   output logic       halted,
   output logic [3:0] dbg_state
);

   typedef enum logic [3:0] {
      StFetch0 = 4'd0,
      StFetch1 = 4'd1,
      StFetch2 = 4'd2,
      StDecode = 4'd3,
      StOpa0   = 4'd4,
      StOpa1   = 4'd5,
      StEx0    = 4'd6,
      StEx1    = 4'd7,
      StEx2    = 4'd8,
      StHalt   = 4'd9
   } state_t;

   localparam logic [3:0] AluAdd = 4'b0000;
   localparam logic [3:0] AluAnd = 4'b0001;
   localparam logic [3:0] AluOr  = 4'b0010;
   localparam logic [3:0] AluNot = 4'b0011;

   localparam logic [1:0] AddrRdm = 2'b00;
   localparam logic [1:0] AddrPc  = 2'b01;
   localparam logic [1:0] AddrSp  = 2'b10;

   localparam logic [1:0] DataAc = 2'b00;
   localparam logic [1:0] DataPc = 2'b01;
   localparam logic [1:0] DataX  = 2'b10;

   state_t state;

   logic ext;
   logic i_sta, i_lda, i_add, i_or, i_and, i_not;
   logic i_jmp, i_jn, i_jz, i_jc, i_in, i_out, i_ldi, i_hlt;
   logic i_push, i_pop, i_call, i_ret;
   logic i_ldx, i_stx, i_ldxi, i_tax, i_txa, i_inx;
   logic jump, jump_taken, needs_operand, direct_ex, mem_op, two_step, three_step;

   assign ext    = (opcode == 4'h7);
   assign i_sta  = (opcode == 4'h1);
   assign i_lda  = (opcode == 4'h2);
   assign i_add  = (opcode == 4'h3);
   assign i_or   = (opcode == 4'h4);
   assign i_and  = (opcode == 4'h5);
   assign i_not  = (opcode == 4'h6);
   assign i_jmp  = (opcode == 4'h8);
   assign i_jn   = (opcode == 4'h9);
   assign i_jz   = (opcode == 4'hA);
   assign i_jc   = (opcode == 4'hB);
   assign i_in   = (opcode == 4'hC);
   assign i_out  = (opcode == 4'hD);
   assign i_ldi  = (opcode == 4'hE);
   assign i_hlt  = (opcode == 4'hF);
   assign i_push = ext && (sub_opcode == 4'h0);
   assign i_pop  = ext && (sub_opcode == 4'h1);
   assign i_call = ext && (sub_opcode == 4'h2);
   assign i_ret  = ext && (sub_opcode == 4'h3);

`ifdef NEANDER_X_INDEX_EN
   assign i_ldx  = ext && (sub_opcode == 4'h4);
   assign i_stx  = ext && (sub_opcode == 4'h5);
   assign i_ldxi = ext && (sub_opcode == 4'h6);
   assign i_tax  = ext && (sub_opcode == 4'hD);
   assign i_txa  = ext && (sub_opcode == 4'hE);
   assign i_inx  = ext && (sub_opcode == 4'hF);
`else
   // Without the extension these subs fall through to the NOP path.
   assign i_ldx  = 1'b0;
   assign i_stx  = 1'b0;
   assign i_ldxi = 1'b0;
   assign i_tax  = 1'b0;
   assign i_txa  = 1'b0;
   assign i_inx  = 1'b0;
`endif

   assign jump          = i_jmp || i_jn || i_jz || i_jc;
   assign jump_taken    = i_jmp || (i_jn && flagN) || (i_jz && flagZ) || (i_jc && flagC);
   assign mem_op        = i_lda || i_add || i_or || i_and || i_ldx || i_sta || i_stx;
   assign needs_operand = mem_op || jump || i_in || i_out || i_ldi || i_call || i_ldxi;
   assign direct_ex     = i_not || i_tax || i_txa || i_inx || i_push || i_pop || i_ret;
   assign two_step      = mem_op || i_push || i_pop || i_call || i_ret;
   assign three_step    = i_push || i_call || i_ret;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= StFetch0;
      end else begin
         unique case (state)
            StFetch0: state <= run ? StFetch1 : StFetch0;
            StFetch1: state <= StFetch2;
            StFetch2: state <= StDecode;
            StDecode: begin
               if (i_hlt)              state <= StHalt;
               else if (needs_operand) state <= StOpa0;
               else if (direct_ex)     state <= StEx0;
               else                    state <= StFetch0;
            end
            StOpa0:   state <= StOpa1;
            StOpa1:   state <= (i_ldi || i_ldxi) ? StFetch0 : StEx0;
            StEx0:    state <= two_step ? StEx1 : StFetch0;
            StEx1:    state <= three_step ? StEx2 : StFetch0;
            StEx2:    state <= StFetch0;
            StHalt:   state <= StHalt;
            default:  state <= StFetch0;
         endcase
      end
   end

   assign dbg_state = state;

   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      rdm_load      = 1'b0;
      rem_load      = 1'b0;
      ri_load       = 1'b0;
      pc_inc        = 1'b0;
      pc_load       = 1'b0;
      ac_load       = 1'b0;
      nz_load       = 1'b0;
      c_load        = 1'b0;
      sp_inc        = 1'b0;
      sp_dec        = 1'b0;
      x_load        = 1'b0;
      x_inc         = 1'b0;
      x_to_ac       = 1'b0;
      indexed_mode  = 1'b0;
      addr_sel      = AddrRdm;
      mem_data_sel  = DataAc;
      alu_op        = AluAdd;
      alu_b_sel     = 1'b0;
      io_write_ctrl = 1'b0;
      halted        = 1'b0;
      // Reset masks everything so no strobe leaks while the async reset is held.
      if (!reset) begin
         unique case (state)
            StFetch0: begin
               if (run) begin
                  rem_load = 1'b1;
                  addr_sel = AddrPc;
               end
            end
            StFetch1, StOpa1: begin
               mem_read = 1'b1;
               rdm_load = 1'b1;
               pc_inc   = 1'b1;
               if (state == StOpa1 && i_ldi) begin
                  ac_load = 1'b1;
                  nz_load = 1'b1;
               end
               if (state == StOpa1 && i_ldxi) x_load = 1'b1;
            end
            StFetch2: ri_load = 1'b1;
            StOpa0: begin
               rem_load = 1'b1;
               addr_sel = AddrPc;
            end
            StEx0: begin
               if (mem_op) rem_load = 1'b1;
               if (i_push || i_call) sp_dec = 1'b1;
               if (i_pop || i_ret) begin
                  rem_load = 1'b1;
                  addr_sel = AddrSp;
               end
               if (jump_taken) pc_load = 1'b1;
               if (i_in || i_not || i_txa) begin
                  ac_load = 1'b1;
                  nz_load = 1'b1;
               end
               if (i_not) alu_op = AluNot;
               if (i_out) io_write_ctrl = 1'b1;
               if (i_tax) x_load = 1'b1;
               if (i_txa) x_to_ac = 1'b1;
               if (i_inx) x_inc = 1'b1;
            end
            StEx1: begin
               if (i_lda || i_add || i_or || i_and || i_ldx || i_pop || i_ret) mem_read = 1'b1;
               if (i_lda || i_add || i_or || i_and || i_pop) begin
                  ac_load = 1'b1;
                  nz_load = 1'b1;
               end
               if (i_add || i_or || i_and) c_load = 1'b1;
               if (i_or)  alu_op = AluOr;
               if (i_and) alu_op = AluAnd;
               if (i_ldx) x_load = 1'b1;
               if (i_sta || i_stx) mem_write = 1'b1;
               if (i_stx) mem_data_sel = DataX;
`ifdef NEANDER_X_INDEX_EN
               if (i_lda || i_sta) indexed_mode = sub_opcode[0];
`endif
               if (i_push || i_call) begin
                  rem_load = 1'b1;
                  addr_sel = AddrSp;
               end
               if (i_pop || i_ret) sp_inc = 1'b1;
               if (i_ret) rdm_load = 1'b1;
            end
            StEx2: begin
               if (i_push || i_call) mem_write = 1'b1;
               if (i_call) mem_data_sel = DataPc;
               if (i_call || i_ret) pc_load = 1'b1;
            end
            StHalt: halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule
